reg_file_oe: RTL and testbench
==============================

Name: reg_file_oe

Overview:
- Parametrised register file; successor to the single-register output-enable cell.
- Width, depth and read latency are generalised. One write port, two tri-stated read ports for a shared bus, one unswitched debug read port.
- Adds write-to-read bypass, synchronous clear, optional hardwired-zero R0, and a per-register busy scoreboard (reserve/ready) for the datapath controller.

Parameters:
N, 16, data width in bits
DEPTH, 16, number of registers (power of two, >=2)
AW, 4, address width = log2(DEPTH)
RD_LAT, 0, read latency: 0 = combinational read, 1 = registered read
ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes and reservations

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Clr  in  1  synchronous clear of all registers and busy bits
Ld  in  1  write enable
WA  in  AW  write address
I  in  N  write data
Rsv  in  1  reserve request: mark RsvA busy
RsvA  in  AW  reserve address
RA0  in  AW  read address, port 0
RA1  in  AW  read address, port 1
Oe0  in  1  output enable, port 0
Oe1  in  1  output enable, port 1
DA  in  AW  debug read address
Qz0  out  N  tri-state read data, port 0
Qz1  out  N  tri-state read data, port 1
Rdy0  out  1  port 0 data valid (register not busy)
Rdy1  out  1  port 1 data valid
DQ  out  N  unswitched debug read of DA; combinational, no bypass

Behaviour:
- Reset (Rst_n=0, async): all registers = 0; all busy bits = 0; RD_LAT=1 pipeline regs = 0 and delayed Oe = 0, so Qz0/Qz1 = Z; Rdy0/Rdy1 = 1.
- Write: on rising Clk with Ld=1 and Clr=0, reg[WA] <= I. With ZERO_R0=1 and WA=0, the write is dropped.
- Clr: on rising Clk, all registers <= 0 and all busy bits <= 0. Clr overrides Ld and Rsv in the same cycle.
- Scoreboard:
  - Rsv=1 sets busy[RsvA].
  - Ld=1 clears busy[WA].
  - If Rsv and Ld hit the same address in the same cycle, busy stays 1 (new producer wins).
  - ZERO_R0=1: busy[0] is never set.
- Read value, per port p:
  - val = (Ld && !Clr && WA==RAp && !(ZERO_R0 && WA==0)) ? I : reg[RAp].
  - Write-first bypass.
  - Forced to 0 when ZERO_R0=1 and RAp=0.
- Ready, per port p: rdy = !busy[RAp] || (Ld && !Clr && WA==RAp). A bypassed write counts as ready.
- RD_LAT=0:
  - Qzp = Oep ? val : Z, combinational.
  - Rdyp = rdy, combinational.
- RD_LAT=1:
  - On rising Clk, capture val, rdy and Oep into pipeline regs.
  - Qzp = Oe_q ? val_q : Z. Rdyp = rdy_q.
  - Data, enable and ready all appear exactly one cycle after the address, so the tri-state is aligned with its data.
  - Clr clears val_q to 0 and rdy_q to 1; Oe_q still follows Oep.
- Both ports may read the same address; both may be enabled at once. Driving both onto one bus is an integration error and is not checked here.
- DQ = reg[DA] (0 for DA=0 when ZERO_R0). Reflects the state before the current edge; no bypass.
- Out-of-range addresses cannot occur (DEPTH = 2^AW).
- Reset asserted mid-pipeline discards captured reads immediately.

Test Plan:
1. Reset, then write 0x1234 to R5, set RA0=5, Oe0=1 -> RD_LAT=0: Qz0=0x1234 the same cycle as Ld (bypass) and after. RD_LAT=1: Qz0=0x1234 one cycle after RA0 is presented. Oe0=0 -> Qz0=Z.
2. Rsv with RsvA=3, then RA1=3 -> Rdy1=0. On the cycle Ld writes 0xBEEF to WA=3 -> Rdy1=1 (bypass) and Qz1=0xBEEF. The following cycle busy[3]=0.
3. Rsv and Ld on address 7 in the same cycle with I=0x00AA -> reg[7]=0x00AA, busy[7]=1, Rdy0=0 for RA0=7.
4. Fill R1..R15 with distinct values, pulse Clr with Ld=1 on WA=2 -> every register reads 0 (including R2) and all Rdy=1.
5. ZERO_R0=1: write 0xFFFF to R0 and Rsv on R0 -> Qz0 with RA0=0 is 0, Rdy0=1, DQ (DA=0) = 0.
6. RD_LAT=1: read R4=0x0F0F, then drop Rst_n low mid-read -> Qz0/Qz1=Z and DQ=0 immediately, without a clock edge. After release, a re-read of R4 returns 0.

Source files
------------

// File: rtl/reg_file_oe_if.sv
// Bus bundle for reg_file_oe: write port, scoreboard, read addressing and the
// unswitched debug/ready returns. The tri-stated data lines stay outside the bundle.
interface reg_file_oe_if #(
  parameter int N  = 16,
  parameter int AW = 4
);
  logic          clr;
  logic          ld;
  logic [AW-1:0] wa;
  logic [N-1:0]  wdata;
  logic          rsv;
  logic [AW-1:0] rsv_a;
  logic [AW-1:0] ra0;
  logic [AW-1:0] ra1;
  logic          oe0;
  logic          oe1;
  logic [AW-1:0] da;
  logic          rdy0;
  logic          rdy1;
  logic [N-1:0]  dq;

  modport master (
    output clr, ld, wa, wdata, rsv, rsv_a, ra0, ra1, oe0, oe1, da,
    input  rdy0, rdy1, dq
  );

  modport slave (
    input  clr, ld, wa, wdata, rsv, rsv_a, ra0, ra1, oe0, oe1, da,
    output rdy0, rdy1, dq
  );
endinterface

// File: rtl/reg_file_oe.sv
// Parametrised register file: one write port, two tri-stated read ports with
// write-first bypass, a debug read port and a per-register busy scoreboard.
module reg_file_oe #(
  parameter int N       = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int RD_LAT  = 0,
  parameter int ZERO_R0 = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_oe_if.slave bus,
  // Kept as plain nets so they can be resolved on the shared bus by the integrator.
  output wire [N-1:0]  qz0,
  output wire [N-1:0]  qz1
);

  localparam bit ZR = (ZERO_R0 != 0);

  logic [N-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic          wr_en;

  logic [AW-1:0] ra    [2];
  logic          oe    [2];
  logic [1:0]    wr_hit;
  logic [N-1:0]  val   [2];
  logic          rdy   [2];
  logic [N-1:0]  val_o [2];
  logic          rdy_o [2];
  logic          oe_o  [2];

  assign ra[0] = bus.ra0;
  assign ra[1] = bus.ra1;
  assign oe[0] = bus.oe0;
  assign oe[1] = bus.oe1;

  assign wr_en = bus.ld && !bus.clr && !(ZR && bus.wa == '0);

  // NOTE: every register gets an async reset, so this maps to flops, not a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else if (bus.clr) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else if (wr_en) begin
      mem[bus.wa] <= bus.wdata;
    end
  end

  // Reservation is applied after the write's release so a same-address pair stays busy.
  // NOTE: assign the default first so every path drives busy_nxt and no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (bus.ld) busy_nxt[bus.wa] = 1'b0;
    if (bus.rsv && !(ZR && bus.rsv_a == '0)) busy_nxt[bus.rsv_a] = 1'b1;
  end

  // NOTE: state updates use non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (bus.clr) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_hit[p] = bus.ld && !bus.clr && (bus.wa == ra[p]);
      if (ZR && ra[p] == '0) begin
        val[p] = '0;
      end else if (wr_hit[p]) begin
        val[p] = bus.wdata;
      end else begin
        val[p] = mem[ra[p]];
      end
      rdy[p] = !busy[ra[p]] || wr_hit[p];
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    logic [N-1:0] val_q [2];
    logic         rdy_q [2];
    logic         oe_q  [2];

    // Enable is pipelined with the data so the bus driver switches in step with it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int p = 0; p < 2; p++) begin
          val_q[p] <= '0;
          rdy_q[p] <= 1'b1;
          oe_q[p]  <= 1'b0;
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          oe_q[p] <= oe[p];
          if (bus.clr) begin
            val_q[p] <= '0;
            rdy_q[p] <= 1'b1;
          end else begin
            val_q[p] <= val[p];
            rdy_q[p] <= rdy[p];
          end
        end
      end
    end

    assign val_o = val_q;
    assign rdy_o = rdy_q;
    assign oe_o  = oe_q;
  end else begin : g_lat0
    assign val_o = val;
    assign rdy_o = rdy;
    assign oe_o  = oe;
  end

  assign qz0 = oe_o[0] ? val_o[0] : {N{1'bz}};
  assign qz1 = oe_o[1] ? val_o[1] : {N{1'bz}};

  assign bus.rdy0 = rdy_o[0];
  assign bus.rdy1 = rdy_o[1];

  // Debug port shows committed state only; it never sees the write bypass.
  assign bus.dq = (ZR && bus.da == '0) ? '0 : mem[bus.da];

endmodule

// File: tb/tb_reg_file_oe.sv
// Bench for reg_file_oe: instance A (combinational read, no zero R0) and
// instance B (registered read, hardwired R0) share one directed stimulus.
module tb_reg_file_oe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_clr, s_ld, s_rsv, s_oe0, s_oe1;
  logic [3:0]  s_wa, s_rsva, s_ra0, s_ra1, s_da;
  logic [15:0] s_wd;

  int checks   = 0;
  int failures = 0;
  bit run      = 1'b0;

  reg_file_oe_if #(.N(16), .AW(4)) bus_a ();
  reg_file_oe_if #(.N(16), .AW(4)) bus_b ();

  // Undriven tri-state lines float high, so a released bus reads 16'hFFFF.
  wire [15:0] qz0_a, qz1_a, qz0_b, qz1_b;
  pullup pu_0a (qz0_a);
  pullup pu_1a (qz1_a);
  pullup pu_0b (qz0_b);
  pullup pu_1b (qz1_b);

  assign bus_a.clr = s_clr;   assign bus_b.clr = s_clr;
  assign bus_a.ld = s_ld;     assign bus_b.ld = s_ld;
  assign bus_a.wa = s_wa;     assign bus_b.wa = s_wa;
  assign bus_a.wdata = s_wd;  assign bus_b.wdata = s_wd;
  assign bus_a.rsv = s_rsv;   assign bus_b.rsv = s_rsv;
  assign bus_a.rsv_a = s_rsva; assign bus_b.rsv_a = s_rsva;
  assign bus_a.ra0 = s_ra0;   assign bus_b.ra0 = s_ra0;
  assign bus_a.ra1 = s_ra1;   assign bus_b.ra1 = s_ra1;
  assign bus_a.oe0 = s_oe0;   assign bus_b.oe0 = s_oe0;
  assign bus_a.oe1 = s_oe1;   assign bus_b.oe1 = s_oe1;
  assign bus_a.da = s_da;     assign bus_b.da = s_da;

  reg_file_oe #(.N(16), .DEPTH(16), .AW(4), .RD_LAT(0), .ZERO_R0(0)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .qz0(qz0_a), .qz1(qz1_a)
  );
  reg_file_oe #(.N(16), .DEPTH(16), .AW(4), .RD_LAT(1), .ZERO_R0(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .qz0(qz0_b), .qz1(qz1_b)
  );

  // Reference model: index 0 = instance A, index 1 = instance B.
  logic [15:0] m_reg [2][16];
  logic        m_busy [2][16];
  logic [15:0] m_vq [2][2];
  logic        m_rq [2][2];
  logic        m_oq [2][2];

  function automatic bit zr(input int k);
    return k == 1;
  endfunction

  function automatic logic [15:0] exp_val(input int k, input logic [3:0] ra);
    if (zr(k) && ra == 4'd0) return 16'h0000;
    if (s_ld && !s_clr && s_wa == ra) return s_wd;
    return m_reg[k][ra];
  endfunction

  function automatic logic exp_rdy(input int k, input logic [3:0] ra);
    return !m_busy[k][ra] || (s_ld && !s_clr && s_wa == ra);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int a = 0; a < 16; a++) begin
          m_reg[k][a]  <= 16'h0000;
          m_busy[k][a] <= 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
          m_vq[k][p] <= 16'h0000;
          m_rq[k][p] <= 1'b1;
          m_oq[k][p] <= 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_oq[k][0] <= s_oe0;
        m_oq[k][1] <= s_oe1;
        m_vq[k][0] <= s_clr ? 16'h0000 : exp_val(k, s_ra0);
        m_vq[k][1] <= s_clr ? 16'h0000 : exp_val(k, s_ra1);
        m_rq[k][0] <= s_clr ? 1'b1 : exp_rdy(k, s_ra0);
        m_rq[k][1] <= s_clr ? 1'b1 : exp_rdy(k, s_ra1);
        if (s_clr) begin
          for (int a = 0; a < 16; a++) begin
            m_reg[k][a]  <= 16'h0000;
            m_busy[k][a] <= 1'b0;
          end
        end else begin
          if (s_ld && !(zr(k) && s_wa == 4'd0)) m_reg[k][s_wa] <= s_wd;
          if (s_ld) m_busy[k][s_wa] <= 1'b0;
          if (s_rsv && !(zr(k) && s_rsva == 4'd0)) m_busy[k][s_rsva] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input string pre, input logic [15:0] q0, input logic [15:0] q1,
                     input logic r0, input logic r1, input logic [15:0] dq);
    logic [15:0] e_q0, e_q1, e_dq;
    logic        e_r0, e_r1;
    if (k == 1) begin
      e_q0 = m_oq[k][0] ? m_vq[k][0] : 16'hFFFF;
      e_q1 = m_oq[k][1] ? m_vq[k][1] : 16'hFFFF;
      e_r0 = m_rq[k][0];
      e_r1 = m_rq[k][1];
    end else begin
      e_q0 = s_oe0 ? exp_val(k, s_ra0) : 16'hFFFF;
      e_q1 = s_oe1 ? exp_val(k, s_ra1) : 16'hFFFF;
      e_r0 = exp_rdy(k, s_ra0);
      e_r1 = exp_rdy(k, s_ra1);
    end
    e_dq = (zr(k) && s_da == 4'd0) ? 16'h0000 : m_reg[k][s_da];
    check({pre, ".qz0"}, q0, e_q0);
    check({pre, ".qz1"}, q1, e_q1);
    check({pre, ".rdy0"}, {15'd0, r0}, {15'd0, e_r0});
    check({pre, ".rdy1"}, {15'd0, r1}, {15'd0, e_r1});
    check({pre, ".dq"}, dq, e_dq);
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp(0, "model.A", qz0_a, qz1_a, bus_a.rdy0, bus_a.rdy1, bus_a.dq);
      cmp(1, "model.B", qz0_b, qz1_b, bus_b.rdy0, bus_b.rdy1, bus_b.dq);
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    s_clr = 0; s_ld = 0; s_rsv = 0; s_wa = 0; s_wd = 0; s_rsva = 0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    s_ra0 = 0; s_ra1 = 0; s_oe0 = 0; s_oe1 = 0; s_da = 0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    run = 1'b1;
    nxt(); mid();
    check("reset.A.qz0_z", qz0_a, 16'hFFFF);
    check("reset.A.rdy0", {15'd0, bus_a.rdy0}, 16'd1);
    check("reset.A.dq", bus_a.dq, 16'h0000);
    check("reset.B.qz1_z", qz1_b, 16'hFFFF);
    check("reset.B.rdy1", {15'd0, bus_b.rdy1}, 16'd1);
    rst_n = 1'b1;

    // Write R5 with read bypass on port 0
    nxt(); s_ld = 1; s_wa = 5; s_wd = 16'h1234; s_ra0 = 5; s_oe0 = 1;
    mid(); check("t1.A.bypass", qz0_a, 16'h1234);
    check("t1.B.not_yet", qz0_b, 16'hFFFF);
    nxt(); idle();
    mid(); check("t1.A.after", qz0_a, 16'h1234);
    check("t1.B.lat1", qz0_b, 16'h1234);
    nxt(); s_oe0 = 0;
    mid(); check("t1.A.oe_off", qz0_a, 16'hFFFF);
    check("t1.B.oe_lag", qz0_b, 16'h1234);
    nxt();
    mid(); check("t1.B.oe_off", qz0_b, 16'hFFFF);

    // Reserve R3, then satisfy it by a write
    nxt(); s_rsv = 1; s_rsva = 3; s_ra1 = 3; s_oe1 = 1;
    mid(); check("t2.A.rdy_pre", {15'd0, bus_a.rdy1}, 16'd1);
    nxt(); idle();
    mid(); check("t2.A.busy", {15'd0, bus_a.rdy1}, 16'd0);
    nxt(); s_ld = 1; s_wa = 3; s_wd = 16'hBEEF;
    mid(); check("t2.A.rdy_bypass", {15'd0, bus_a.rdy1}, 16'd1);
    check("t2.A.qz1_bypass", qz1_a, 16'hBEEF);
    check("t2.B.busy_lat", {15'd0, bus_b.rdy1}, 16'd0);
    nxt(); idle();
    mid(); check("t2.A.rdy_after", {15'd0, bus_a.rdy1}, 16'd1);
    check("t2.B.qz1", qz1_b, 16'hBEEF);
    check("t2.B.rdy1", {15'd0, bus_b.rdy1}, 16'd1);

    // Reserve and write R7 in the same cycle: new producer keeps it busy
    nxt(); s_rsv = 1; s_rsva = 7; s_ld = 1; s_wa = 7; s_wd = 16'h00AA;
    s_ra0 = 7; s_oe0 = 1; s_oe1 = 0; s_da = 7;
    mid(); check("t3.A.rdy_bypass", {15'd0, bus_a.rdy0}, 16'd1);
    check("t3.A.qz0_bypass", qz0_a, 16'h00AA);
    nxt(); idle();
    mid(); check("t3.A.qz0", qz0_a, 16'h00AA);
    check("t3.A.rdy0_busy", {15'd0, bus_a.rdy0}, 16'd0);
    check("t3.A.dq", bus_a.dq, 16'h00AA);
    nxt();
    mid(); check("t3.B.rdy0_busy", {15'd0, bus_b.rdy0}, 16'd0);
    check("t3.B.qz0", qz0_b, 16'h00AA);

    // Fill R1..R15, reserve two, then clear while writing R2
    for (int k = 1; k < 16; k++) begin
      nxt(); s_ld = 1; s_wa = 4'(k); s_wd = 16'(k * 16'h0101);
    end
    nxt(); idle(); s_rsv = 1; s_rsva = 9;
    nxt(); s_rsva = 12; s_ra0 = 9; s_da = 15;
    mid(); check("t4.A.rdy_r9", {15'd0, bus_a.rdy0}, 16'd0);
    check("t4.A.dq_r15", bus_a.dq, 16'h0F0F);
    nxt(); s_clr = 1; s_ld = 1; s_wa = 2; s_wd = 16'h5555; s_rsv = 1; s_rsva = 6;
    for (int a = 0; a < 16; a++) begin
      nxt(); idle(); s_ra0 = 4'(a); s_ra1 = 4'(a); s_da = 4'(a); s_oe0 = 1; s_oe1 = 1;
      mid();
      check("t4.A.qz0_clr", qz0_a, 16'h0000);
      check("t4.A.rdy1_clr", {15'd0, bus_a.rdy1}, 16'd1);
      check("t4.A.dq_clr", bus_a.dq, 16'h0000);
    end

    // Write and reserve R0: A stores it, B ignores both
    nxt(); s_ld = 1; s_wa = 0; s_wd = 16'hFFFF; s_rsv = 1; s_rsva = 0;
    s_ra0 = 0; s_oe0 = 1; s_oe1 = 0; s_da = 0;
    mid(); check("t5.A.bypass_r0", qz0_a, 16'hFFFF);
    check("t5.B.dq_r0", bus_b.dq, 16'h0000);
    nxt(); idle();
    mid(); check("t5.B.qz0_r0", qz0_b, 16'h0000);
    check("t5.B.rdy0_r0", {15'd0, bus_b.rdy0}, 16'd1);
    check("t5.A.dq_r0", bus_a.dq, 16'hFFFF);
    check("t5.A.rdy0_r0", {15'd0, bus_a.rdy0}, 16'd0);
    nxt();
    mid(); check("t5.B.rdy0_r0_lat", {15'd0, bus_b.rdy0}, 16'd1);

    // Read R4, then reset asynchronously in the middle of the read
    nxt(); s_ld = 1; s_wa = 4; s_wd = 16'h0F0F; s_oe0 = 0;
    nxt(); idle(); s_ra0 = 4; s_ra1 = 4; s_oe0 = 1; s_oe1 = 1; s_da = 4;
    mid(); check("t6.A.qz0", qz0_a, 16'h0F0F);
    nxt();
    mid(); check("t6.B.qz0", qz0_b, 16'h0F0F);
    check("t6.B.qz1", qz1_b, 16'h0F0F);
    check("t6.B.dq", bus_b.dq, 16'h0F0F);
    rst_n = 1'b0;
    #1;
    check("t6.B.qz0_async", qz0_b, 16'hFFFF);
    check("t6.B.qz1_async", qz1_b, 16'hFFFF);
    check("t6.B.dq_async", bus_b.dq, 16'h0000);
    check("t6.A.qz0_async", qz0_a, 16'h0000);
    nxt(); mid();
    rst_n = 1'b1;
    nxt();
    mid(); check("t6.B.reread", qz0_b, 16'h0000);
    check("t6.A.reread", qz0_a, 16'h0000);
    nxt(); mid();

    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
